// File: rtl/vga_line_scan_pkg.sv
// Shared constants and helpers for the VGA line-buffer read side.
// Optional feature macro: VGA_PALETTE_EN (adds a palette stage, latency 4).
package vga_pkg;

    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd751;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd491;
    localparam logic [9:0] V_TOTAL  = 10'd525;

`ifdef VGA_PALETTE_EN
    localparam int LATENCY = 4;
`else
    localparam int LATENCY = 3;
`endif

    // Expand an RGB332 byte to 4:4:4 by repeating the top bits of each field.
    function automatic logic [11:0] rgb332(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/vga_line_scan_if.sv
// Bundle of the line-buffer write port, scan counters and monitor pins.
// Palette write signals exist only when VGA_PALETTE_EN is defined.
interface vga_line_scan_if;
    logic [9:0]  vgax;
    logic [9:0]  vgay;
    logic [9:0]  vgad;
    logic [7:0]  Do;
    logic        vgaw;
`ifdef VGA_PALETTE_EN
    logic [7:0]  pal_a;
    logic [11:0] pal_d;
    logic        pal_w;
`endif
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        collide;

`ifdef VGA_PALETTE_EN
    modport master (
        output vgax, vgay, vgad, Do, vgaw, pal_a, pal_d, pal_w,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b, collide
    );
    modport slave (
        input  vgax, vgay, vgad, Do, vgaw, pal_a, pal_d, pal_w,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b, collide
    );
`else
    modport master (
        output vgax, vgay, vgad, Do, vgaw,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b, collide
    );
    modport slave (
        input  vgax, vgay, vgad, Do, vgaw,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b, collide
    );
`endif
endinterface

// File: rtl/vga_line_ram.sv
// Simple dual-port RAM, one write port and one registered read-first read
// port, written so synthesis maps it onto block RAM. Used for the line
// buffer and for the optional palette.
module vga_line_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write and read on the same edge; the read samples the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_line_scan.sv
// Read side of the SDRAM video line buffer: reads the half not being
// filled, doubles pixels horizontally and drives VGA sync and colour.
// Optional feature macro: VGA_PALETTE_EN (palette lookup, latency 4).
module vga_line_scan
    import vga_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    vga_line_scan_if.slave bus
);
    logic [9:0]  raddr_d, raddr_q;
    logic        visible_d, vis1_q, vis2_q;
    logic        hs_d, hs1_q, hs2_q;
    logic        vs_d, vs1_q, vs2_q;
    logic        collide_d, collide_q;
    logic [7:0]  lineData;
    logic [11:0] colour_d, rgb_q;
    logic        hsTail, vsTail, hsOut_q, vsOut_q;

    // Decode the scan position into read address, visibility, syncs and collision.
    always_comb begin
        visible_d = (bus.vgax < H_VIS) && (bus.vgay < V_VIS);
        hs_d      = !((bus.vgax >= H_SYNC_S) && (bus.vgax <= H_SYNC_E));
        vs_d      = !((bus.vgay >= V_SYNC_S) && (bus.vgay <= V_SYNC_E));
        raddr_d   = {~bus.vgay[0], bus.vgax[9:1]};
        collide_d = collide_q | (bus.vgaw && (bus.vgad[9] == ~bus.vgay[0]) && visible_d);
    end

    // Stage 1: register the read address with its flags; syncs idle high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            raddr_q   <= '0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            collide_q <= 1'b0;
        end else begin
            raddr_q   <= raddr_d;
            vis1_q    <= visible_d;
            hs1_q     <= hs_d;
            vs1_q     <= vs_d;
            collide_q <= collide_d;
        end
    end

    vga_line_ram #(.WIDTH(8), .DEPTH(1024)) u_line (
        .clk     (clock),
        .we_i    (bus.vgaw),
        .waddr_i (bus.vgad),
        .wdata_i (bus.Do),
        .raddr_i (raddr_q),
        .rdata_o (lineData)
    );

    // Stage 2: flags follow the RAM read so they stay aligned with the byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vis2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            vis2_q <= vis1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

`ifdef VGA_PALETTE_EN
    logic [11:0] palData;
    logic        vis3_q, hs3_q, vs3_q;

    vga_line_ram #(.WIDTH(12), .DEPTH(256)) u_palette (
        .clk     (clock),
        .we_i    (bus.pal_w),
        .waddr_i (bus.pal_a),
        .wdata_i (bus.pal_d),
        .raddr_i (lineData),
        .rdata_o (palData)
    );

    // Stage 3: flags wait one more clock while the palette is read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vis3_q <= 1'b0;
            hs3_q  <= 1'b1;
            vs3_q  <= 1'b1;
        end else begin
            vis3_q <= vis2_q;
            hs3_q  <= hs2_q;
            vs3_q  <= vs2_q;
        end
    end

    // Palette entry is the colour; blank outside the visible region.
    always_comb begin
        colour_d = vis3_q ? palData : 12'h000;
        hsTail   = hs3_q;
        vsTail   = vs3_q;
    end
`else
    // Fixed RGB332 expansion; blank outside the visible region.
    always_comb begin
        colour_d = vis2_q ? rgb332(lineData) : 12'h000;
        hsTail   = hs2_q;
        vsTail   = vs2_q;
    end
`endif

    // Output stage: monitor pins come straight from registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hsOut_q <= 1'b1;
            vsOut_q <= 1'b1;
        end else begin
            rgb_q   <= colour_d;
            hsOut_q <= hsTail;
            vsOut_q <= vsTail;
        end
    end

    assign bus.vga_r   = rgb_q[11:8];
    assign bus.vga_g   = rgb_q[7:4];
    assign bus.vga_b   = rgb_q[3:0];
    assign bus.vga_hs  = hsOut_q;
    assign bus.vga_vs  = vsOut_q;
    assign bus.collide = collide_q;
endmodule

// File: tb/tb_vga_line_scan.sv
// Self-checking bench for vga_line_scan: directed scan sequences with
// hand-computed colours plus a cycle-by-cycle expectation queue.
// With VGA_PALETTE_EN the palette is first loaded with the RGB332 mapping.
module tb_vga_line_scan;

`ifdef VGA_PALETTE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } expT;

    logic clock = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;
    int   hsLowCnt   = 0;
    int   vsLowCnt   = 0;
    logic collideExp = 1'b0;
    expT  hist[$];
    logic [7:0] mem [1024];
`ifdef VGA_PALETTE_EN
    logic [11:0] palMem [256];
`endif

    vga_line_scan_if bus();

    vga_line_scan dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    // Count a comparison and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // RGB332 written arithmetically: 3-bit field x -> 2x+msb, 2-bit field x -> 5x.
    function automatic logic [11:0] fixedColour(input logic [7:0] b);
        int r, g, bl;
        r  = (b >> 5) * 2 + (b >> 7);
        g  = ((b >> 2) & 7) * 2 + ((b >> 4) & 1);
        bl = (b & 3) * 5;
        return {r[3:0], g[3:0], bl[3:0]};
    endfunction

    function automatic logic [11:0] colourOf(input logic [7:0] b);
`ifdef VGA_PALETTE_EN
        return palMem[b];
`else
        return fixedColour(b);
`endif
    endfunction

    function automatic expT expFor(input logic [9:0] x, input logic [9:0] y);
        expT e;
        logic [9:0] a;
        e.hs  = !(x >= 656 && x <= 751);
        e.vs  = !(y >= 490 && y <= 491);
        a     = {~y[0], x[9:1]};
        e.rgb = (x < 640 && y < 480) ? colourOf(mem[a]) : 12'h000;
        if (reset) begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.rgb = 12'h000;
        end
        return e;
    endfunction

    function automatic logic [13:0] pins();
        return {bus.vga_hs, bus.vga_vs, bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    // Drive one clock of inputs, then compare the output due this clock.
    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic we,
                                 input logic [9:0] wa, input logic [7:0] wd);
        expT  e;
        logic hitNow;
        bus.vgax = x;
        bus.vgay = y;
        bus.vgaw = we;
        bus.vgad = wa;
        bus.Do   = wd;
        if (we) mem[wa] = wd;
        hist.push_back(expFor(x, y));
        hitNow = we && (wa[9] == ~y[0]) && (x < 640) && (y < 480) && !reset;
        @(posedge clock);
        #1;
        bus.vgaw = 1'b0;
        if (hitNow) collideExp = 1'b1;
        if (hist.size() >= LAT) begin
            e = hist.pop_front();
            checkOutput("pins", 32'(pins()), 32'({e.hs, e.vs, e.rgb}));
        end
        checkOutput("collide", 32'(bus.collide), 32'(collideExp));
        if (!bus.vga_hs) hsLowCnt++;
        if (!bus.vga_vs) vsLowCnt++;
    endtask

    task automatic holdPixel(input logic [9:0] x, input logic [9:0] y, input int n);
        for (int k = 0; k < n; k++) applyStimulus(x, y, 1'b0, 10'd0, 8'd0);
    endtask

    // Assert reset mid-cycle and check the pins blank without a clock edge.
    task automatic startReset();
        reset = 1'b1;
        hist.delete();
        for (int k = 0; k < LAT - 1; k++) hist.push_back('{hs: 1'b1, vs: 1'b1, rgb: 12'h000});
        collideExp = 1'b0;
        #2;
        checkOutput("rst_hs", 32'(bus.vga_hs), 32'd1);
        checkOutput("rst_vs", 32'(bus.vga_vs), 32'd1);
        checkOutput("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
        checkOutput("rst_collide", 32'(bus.collide), 32'd0);
    endtask

`ifdef VGA_PALETTE_EN
    task automatic palWrite(input logic [7:0] a, input logic [11:0] d);
        bus.pal_a = a;
        bus.pal_d = d;
        bus.pal_w = 1'b1;
        palMem[a] = d;
        applyStimulus(10'd790, 10'd500, 1'b0, 10'd0, 8'd0);
        bus.pal_w = 1'b0;
    endtask
`endif

    initial begin
        bus.vgax = 10'd790;
        bus.vgay = 10'd500;
        bus.vgad = '0;
        bus.Do   = '0;
        bus.vgaw = 1'b0;
`ifdef VGA_PALETTE_EN
        bus.pal_a = '0;
        bus.pal_d = '0;
        bus.pal_w = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // Power-on reset.
        startReset();
        holdPixel(10'd790, 10'd500, 3);
        reset = 1'b0;

`ifdef VGA_PALETTE_EN
        for (int i = 0; i < 256; i++) palWrite(8'(i), fixedColour(8'(i)));
        palWrite(8'h10, 12'hABC);
`endif

        // Fill half 1 with index, half 0 with inverted index, away from the visible area.
        for (int i = 0; i < 320; i++)
            applyStimulus(10'd790, 10'd500, 1'b1, {1'b1, 9'(i)}, 8'(i));
        for (int i = 0; i < 320; i++)
            applyStimulus(10'd790, 10'd500, 1'b1, {1'b0, 9'(i)}, ~8'(i));
        // Half 0 write during line 500 (showing half 1) must not flag a collision.
        applyStimulus(10'd100, 10'd500, 1'b1, 10'd400, 8'h55);
        checkOutput("no_collide_y500", 32'(bus.collide), 32'd0);

        // Latency: pixel 2 of line 0 shows byte 1 (colour 005) exactly LAT clocks later.
        holdPixel(10'd790, 10'd0, LAT + 1);
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(10'd2, 10'd0, 1'b0, 10'd0, 8'd0);
            if (k < LAT) checkOutput("lat_early", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
            else         checkOutput("lat_first", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h005);
        end

        // One full line of doubling with horizontal sync counted.
        hsLowCnt = 0;
        for (int x = 0; x < 800; x++) holdPixel(10'(x), 10'd0, 4);
        holdPixel(10'd0, 10'd1, LAT);
        checkOutput("hs_low_clocks", 32'(hsLowCnt), 32'd384);

        // RGB332 decode of hand-picked bytes in half 0, shown on line 1.
        applyStimulus(10'd790, 10'd500, 1'b1, 10'd0, 8'hE0);
        applyStimulus(10'd790, 10'd500, 1'b1, 10'd1, 8'h03);
        applyStimulus(10'd790, 10'd500, 1'b1, 10'd2, 8'hFF);
        holdPixel(10'd0, 10'd1, LAT);
        checkOutput("rgb_E0", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hF00);
        holdPixel(10'd2, 10'd1, LAT);
        checkOutput("rgb_03", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h00F);
        holdPixel(10'd4, 10'd1, LAT);
        checkOutput("rgb_FF", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFF);

        // Vertical sync over a full frame of lines.
        vsLowCnt = 0;
        for (int y = 0; y < 525; y++) holdPixel(10'd0, 10'(y), 4);
        holdPixel(10'd0, 10'd0, LAT);
        checkOutput("vs_low_clocks", 32'(vsLowCnt), 32'd8);

        // Collision: half 0 write while line 1 displays half 0.
        checkOutput("collide_before", 32'(bus.collide), 32'd0);
        applyStimulus(10'd100, 10'd1, 1'b1, 10'd400, 8'h77);
        checkOutput("collide_next_clk", 32'(bus.collide), 32'd1);
        holdPixel(10'd120, 10'd300, 5);
        checkOutput("collide_sticky", 32'(bus.collide), 32'd1);

        // Reset mid-frame at y=200, x=300: byte 150 (8'h96) -> colour 9BA.
        holdPixel(10'd300, 10'd200, LAT + 1);
        checkOutput("pre_reset_pixel", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h9BA);
        startReset();
        holdPixel(10'd300, 10'd200, 3);
        reset = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(10'd300, 10'd200, 1'b0, 10'd0, 8'd0);
            if (k < LAT) checkOutput("post_reset_blank", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
            else         checkOutput("post_reset_pixel", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h9BA);
        end
        for (int x = 301; x < 310; x++) holdPixel(10'(x), 10'd200, 4);

`ifdef VGA_PALETTE_EN
        // Palette: byte 8'h10 sits at half 1 index 16, pixel 32 of line 0.
        holdPixel(10'd790, 10'd0, LAT + 1);
        for (int k = 1; k <= LAT; k++) begin
            applyStimulus(10'd32, 10'd0, 1'b0, 10'd0, 8'd0);
            if (k < LAT) checkOutput("pal_early", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
            else         checkOutput("pal_ABC", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hABC);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
